popcnt_rr_sched: RTL and testbench

Round-robin scheduler that shares one serial 1-bit counting engine among NUM_REQ requesters. Each requester hands over a DATA_W-bit word with a valid/ready handshake. The block counts the 1 bits in the word and returns the count tagged with the requester ID. It sits in front of the bit-count datapath so several producers can use one counter without contention.

---
 rtl/popcnt_rr_sched_if.sv | 31 +++
 rtl/popcnt_rr_sched.sv | 150 +++++++++++++++
 tb/tb_popcnt_rr_sched.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/popcnt_rr_sched_if.sv
// Request/result bundle for popcnt_rr_sched.
//   req_valid/req_data/req_ready : per-requester word handoff (requester k uses
//                                   req_data[k*DATA_W +: DATA_W])
//   res_valid/res_ready/res_cnt/res_id : tagged bit-count result
//   busy                         : scheduler is counting or holding a result
// master = requester/consumer side, slave = scheduler side.
interface popcnt_rr_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      res_valid;
  logic                      res_ready;
  logic [CNT_W-1:0]          res_cnt;
  logic [ID_W-1:0]           res_id;
  logic                      busy;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_cnt, res_id, busy
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_cnt, res_id, busy
  );
endinterface

// File: rtl/popcnt_rr_sched.sv
// Round-robin scheduler sharing one bit-count engine among NUM_REQ requesters.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-low reset
//   bus : popcnt_rr_sched_if.slave (request handshake, result handshake, busy)
// Build option: define FAST_POP_EN to count the word combinationally on accept
// (IDLE -> DONE) instead of the serial DATA_W-cycle COUNT state.
module popcnt_rr_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned ID_W    = 2
) (
  input logic                clk,
  input logic                rst,
  popcnt_rr_sched_if.slave   bus
);

`ifdef FAST_POP_EN
  typedef enum logic [1:0] {StIdle, StDone} state_e;
`else
  localparam int unsigned BitCntW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;
`endif

  state_e              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_grant;
  logic                r_res_valid;
  logic [CNT_W-1:0]    r_res_cnt;
  logic [ID_W-1:0]     r_res_id;
  logic                r_busy;
`ifndef FAST_POP_EN
  logic [DATA_W-1:0]   r_shift;
  logic [CNT_W-1:0]    r_acc;
  logic [BitCntW-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]    w_acc_next;
`endif

  int unsigned         w_idx;
  logic                w_found;
  logic [ID_W-1:0]     w_grant_id;
  logic [NUM_REQ-1:0]  w_grant_oh;
  logic [DATA_W-1:0]   w_word;
  logic                w_accept;
  logic [ID_W-1:0]     w_ptr_next;

`ifdef FAST_POP_EN
  function automatic logic [CNT_W-1:0] f_popcnt(input logic [DATA_W-1:0] word);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int unsigned i = 0; i < DATA_W; i++) sum = sum + CNT_W'(word[i]);
    return sum;
  endfunction
`endif

  // First set req_valid bit at or above the pointer, wrapping.
  always_comb begin
    w_idx      = 0;
    w_found    = 1'b0;
    w_grant_id = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx = (32'(r_ptr) + i) % NUM_REQ;
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found    = 1'b1;
        w_grant_id = ID_W'(w_idx);
      end
    end
  end

  // Grant only in IDLE and never while reset is asserted.
  always_comb begin
    w_grant_oh = '0;
    if (rst && (r_state == StIdle) && w_found) w_grant_oh[w_grant_id] = 1'b1;
  end

  assign w_word     = bus.req_data[32'(w_grant_id) * DATA_W +: DATA_W];
  assign w_accept   = |(bus.req_valid & w_grant_oh);
  assign w_ptr_next = (r_grant == ID_W'(NUM_REQ - 1)) ? '0 : r_grant + ID_W'(1);
`ifndef FAST_POP_EN
  assign w_acc_next = r_acc + CNT_W'(r_shift[0]);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_res_valid <= 1'b0;
      r_res_cnt   <= '0;
      r_res_id    <= '0;
      r_busy      <= 1'b0;
`ifndef FAST_POP_EN
      r_shift     <= '0;
      r_acc       <= '0;
      r_bit_cnt   <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_grant <= w_grant_id;
            r_busy  <= 1'b1;
`ifdef FAST_POP_EN
            r_res_cnt   <= f_popcnt(w_word);
            r_res_id    <= w_grant_id;
            r_res_valid <= 1'b1;
            r_state     <= StDone;
`else
            r_shift   <= w_word;
            r_acc     <= '0;
            r_bit_cnt <= '0;
            r_state   <= StCount;
`endif
          end
        end
`ifndef FAST_POP_EN
        StCount: begin
          r_acc     <= w_acc_next;
          r_shift   <= r_shift >> 1;
          r_bit_cnt <= r_bit_cnt + BitCntW'(1);
          // Last bit: publish the final sum directly so DONE shows it at once.
          if (r_bit_cnt == BitCntW'(DATA_W - 1)) begin
            r_res_cnt   <= w_acc_next;
            r_res_id    <= r_grant;
            r_res_valid <= 1'b1;
            r_state     <= StDone;
          end
        end
`endif
        StDone: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_ptr       <= w_ptr_next;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = w_grant_oh;
  assign bus.res_valid = r_res_valid;
  assign bus.res_cnt   = r_res_cnt;
  assign bus.res_id    = r_res_id;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_popcnt_rr_sched.sv
// Self-checking bench for popcnt_rr_sched: a timestamp-based reference model
// checked every cycle on the falling edge, plus directed scenarios with
// hand-computed result sequences.
module tb_popcnt_rr_sched;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
`ifdef FAST_POP_EN
  localparam int LAT = 0;  // result visible right after the accept edge
`else
  localparam int LAT = 8;  // result visible after DATA_W further edges
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  popcnt_rr_sched_if #(.NUM_REQ(4), .DATA_W(8), .CNT_W(4), .ID_W(2)) bus ();

  popcnt_rr_sched #(.NUM_REQ(4), .DATA_W(8), .CNT_W(4), .ID_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nchecks = 0;
  int nfail   = 0;
  int cyc     = 0;

  // Reference model: one result in flight, visible from edge m_due on.
  bit m_inflight = 0;
  int m_due      = 0;
  int m_ptr      = 0;
  int m_id       = 0;
  int m_cnt      = 0;
  int last_acc   = 0;
  int last_rise  = 0;
  bit prev_rv    = 0;
  int got_id[$];
  int got_cnt[$];

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
    end
    return -1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle compare against the model, then advance the model by one edge.
  initial begin
    int g;
    logic [3:0] exp_rdy;
    bit exp_valid;
    logic [7:0] w;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_valid = m_inflight && (cyc >= m_due);
      g = -1;
      if (rst && !m_inflight) g = pick(bus.req_valid, m_ptr);
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
      check("req_ready", int'(bus.req_ready), int'(exp_rdy));
      check("res_valid", int'(bus.res_valid), int'(exp_valid));
      check("busy", int'(bus.busy), int'(m_inflight));
      if (exp_valid) begin
        check("res_cnt", int'(bus.res_cnt), m_cnt);
        check("res_id", int'(bus.res_id), m_id);
      end
      if (bus.res_valid && !prev_rv) last_rise = cyc;
      prev_rv = bus.res_valid;
      if (rst && bus.res_valid && bus.res_ready) begin
        got_id.push_back(int'(bus.res_id));
        got_cnt.push_back(int'(bus.res_cnt));
      end
      if (!rst) begin
        m_inflight = 0;
        m_ptr      = 0;
      end else if (!m_inflight) begin
        if (g >= 0) begin
          w          = bus.req_data[g*DATA_W +: DATA_W];
          m_inflight = 1;
          m_id       = g;
          m_cnt      = $countones(w);
          last_acc   = cyc + 1;
          m_due      = cyc + 1 + LAT;
        end
      end else if (cyc >= m_due && bus.res_ready) begin
        m_inflight = 0;
        m_ptr      = (m_id + 1) % NUM_REQ;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", nchecks);
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(input int k, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!bus.req_ready[k] && n < budget);
    check("grant_seen", int'(bus.req_ready[k]), 1);
  endtask

  task automatic wait_results(input int target, input int budget);
    int n = 0;
    while (got_id.size() < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("result_count", got_id.size(), target);
  endtask

  // Present one word on requester k alone and drop valid on the accept edge.
  task automatic do_one(input int k, input logic [7:0] word);
    @(posedge clk);
    #1;
    bus.req_data[k*DATA_W +: DATA_W] = word;
    bus.req_valid = 4'(1 << k);
    wait_ready(k, 60);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  logic [7:0] t2_word[5] = '{8'hB9, 8'h01, 8'h23, 8'hFF, 8'h00};
  int         t2_cnt[5]  = '{5, 1, 3, 8, 0};
  int         t3_id[5]   = '{0, 1, 2, 3, 0};
  int         t3_cnt[5]  = '{4, 2, 1, 8, 4};
  int         t4_id[3]   = '{1, 3, 1};
  int         t4_cnt[3]  = '{4, 2, 4};

  initial begin
    int base;
    bus.req_valid = 4'hF;
    bus.req_data  = '0;
    bus.res_ready = 1'b0;

    // 1: reset held with all requesters valid.
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", int'(bus.req_ready), 0);
    check("rst_res_cnt", int'(bus.res_cnt), 0);
    check("rst_res_id", int'(bus.res_id), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("first_grant", int'(bus.req_ready), 1);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    wait_results(1, 40);
    check("t1_id", got_id[0], 0);

    // 2: single requester, several words, fixed latency.
    foreach (t2_word[i]) begin
      base = got_id.size();
      do_one(0, t2_word[i]);
      wait_results(base + 1, 40);
      check("t2_cnt", got_cnt[base], t2_cnt[i]);
      check("t2_id", got_id[base], 0);
      check("t2_latency", last_rise - last_acc, LAT);
    end

    // 3: all valid -> strict rotation from 0.
    reset_pulse();
    base = got_id.size();
    bus.req_data  = {8'hFF, 8'h80, 8'h03, 8'h0F};
    bus.req_valid = 4'hF;
    wait_results(base + 5, 80);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      check("t3_id", got_id[base+i], t3_id[i]);
      check("t3_cnt", got_cnt[base+i], t3_cnt[i]);
    end

    // 4: only requesters 1 and 3 valid.
    reset_pulse();
    base = got_id.size();
    bus.req_data  = {8'hC0, 8'hFF, 8'h55, 8'hFF};
    bus.req_valid = 4'b1010;
    wait_results(base + 3, 60);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      check("t4_id", got_id[base+i], t4_id[i]);
      check("t4_cnt", got_cnt[base+i], t4_cnt[i]);
    end

    // 5: result held under back-pressure, then released.
    reset_pulse();
    bus.res_ready = 1'b0;
    base = got_id.size();
    do_one(0, 8'hB9);
    begin
      int n = 0;
      while (!bus.res_valid && n < 40) begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    repeat (10) @(negedge clk);
    #1;
    check("t5_hold_valid", int'(bus.res_valid), 1);
    check("t5_hold_cnt", int'(bus.res_cnt), 5);
    check("t5_hold_id", int'(bus.res_id), 0);
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    bus.req_data[2*DATA_W +: DATA_W] = 8'h0F;
    bus.req_valid = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("t5_idle_busy", int'(bus.busy), 0);
    check("t5_next_grant", int'(bus.req_ready), 4);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    wait_results(base + 2, 40);
    check("t5_id", got_id[base+1], 2);
    check("t5_cnt", got_cnt[base+1], 4);

    // 6: reset during the 4th COUNT cycle discards the result.
    reset_pulse();
    bus.res_ready = 1'b0;
    do_one(0, 8'hFF);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    base = got_id.size();
    bus.req_data[1*DATA_W +: DATA_W] = 8'h07;
    bus.req_valid = 4'b1110;
    wait_ready(1, 10);
    check("t6_grant", int'(bus.req_ready), 2);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    wait_results(base + 1, 40);
    repeat (3) @(negedge clk);
    check("t6_count", got_id.size(), base + 1);
    check("t6_id", got_id[base], 1);
    check("t6_cnt", got_cnt[base], 3);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end
endmodule
